axi_arbiter_2to1: RTL and testbench

//  Shares one AXI4 slave (UART, SRAM) between two masters: m0 = IFU, m1 = LSU.

---
 rtl/axi_arbiter_2to1_pkg.sv | 6 +
 rtl/axi_arbiter_2to1_rr_pick2.sv | 12 +
 rtl/axi_arbiter_2to1.sv | 194 +++++++++++++++++++
 tb/tb_axi_arbiter_2to1.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arbiter_2to1_pkg.sv
// axi_arbiter_2to1_pkg: FSM state encoding and AXI response codes shared by the arbiter and its bench.
package axi_arbiter_2to1_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RD = 2'd1, ST_WR = 2'd2} state_t;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

// File: rtl/axi_arbiter_2to1_rr_pick2.sv
// rr_pick2: two-way round-robin pick; on contention the prio master wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic       gnt_idx,
  output logic       gnt_vld
);
  always_comb begin
    gnt_vld = |req;
    gnt_idx = &req ? prio : req[1];
  end
endmodule

// File: rtl/axi_arbiter_2to1.sv
// axi_arbiter_2to1: whole-transaction round-robin arbiter sharing one AXI4 slave between two masters.
module axi_arbiter_2to1
  import axi_arbiter_2to1_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    m0_awvalid,
  input  logic [ADDR_WIDTH-1:0]   m0_awaddr,
  input  logic [ID_WIDTH-1:0]     m0_awid,
  input  logic [7:0]              m0_awlen,
  input  logic [2:0]              m0_awsize,
  input  logic [1:0]              m0_awburst,
  output logic                    m0_awready,
  input  logic                    m0_wvalid,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
  input  logic                    m0_wlast,
  output logic                    m0_wready,
  output logic                    m0_bvalid,
  output logic [1:0]              m0_bresp,
  output logic [ID_WIDTH-1:0]     m0_bid,
  input  logic                    m0_bready,
  input  logic                    m0_arvalid,
  input  logic [ADDR_WIDTH-1:0]   m0_araddr,
  input  logic [ID_WIDTH-1:0]     m0_arid,
  input  logic [7:0]              m0_arlen,
  input  logic [2:0]              m0_arsize,
  input  logic [1:0]              m0_arburst,
  output logic                    m0_arready,
  output logic                    m0_rvalid,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  output logic [1:0]              m0_rresp,
  output logic [ID_WIDTH-1:0]     m0_rid,
  output logic                    m0_rlast,
  input  logic                    m0_rready,
  input  logic                    m1_awvalid,
  input  logic [ADDR_WIDTH-1:0]   m1_awaddr,
  input  logic [ID_WIDTH-1:0]     m1_awid,
  input  logic [7:0]              m1_awlen,
  input  logic [2:0]              m1_awsize,
  input  logic [1:0]              m1_awburst,
  output logic                    m1_awready,
  input  logic                    m1_wvalid,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
  input  logic                    m1_wlast,
  output logic                    m1_wready,
  output logic                    m1_bvalid,
  output logic [1:0]              m1_bresp,
  output logic [ID_WIDTH-1:0]     m1_bid,
  input  logic                    m1_bready,
  input  logic                    m1_arvalid,
  input  logic [ADDR_WIDTH-1:0]   m1_araddr,
  input  logic [ID_WIDTH-1:0]     m1_arid,
  input  logic [7:0]              m1_arlen,
  input  logic [2:0]              m1_arsize,
  input  logic [1:0]              m1_arburst,
  output logic                    m1_arready,
  output logic                    m1_rvalid,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic [1:0]              m1_rresp,
  output logic [ID_WIDTH-1:0]     m1_rid,
  output logic                    m1_rlast,
  input  logic                    m1_rready,
  output logic                    s_awvalid,
  output logic [ADDR_WIDTH-1:0]   s_awaddr,
  output logic [ID_WIDTH-1:0]     s_awid,
  output logic [7:0]              s_awlen,
  output logic [2:0]              s_awsize,
  output logic [1:0]              s_awburst,
  input  logic                    s_awready,
  output logic                    s_wvalid,
  output logic [DATA_WIDTH-1:0]   s_wdata,
  output logic [DATA_WIDTH/8-1:0] s_wstrb,
  output logic                    s_wlast,
  input  logic                    s_wready,
  input  logic                    s_bvalid,
  input  logic [1:0]              s_bresp,
  input  logic [ID_WIDTH-1:0]     s_bid,
  output logic                    s_bready,
  output logic                    s_arvalid,
  output logic [ADDR_WIDTH-1:0]   s_araddr,
  output logic [ID_WIDTH-1:0]     s_arid,
  output logic [7:0]              s_arlen,
  output logic [2:0]              s_arsize,
  output logic [1:0]              s_arburst,
  input  logic                    s_arready,
  input  logic                    s_rvalid,
  input  logic [DATA_WIDTH-1:0]   s_rdata,
  input  logic [1:0]              s_rresp,
  input  logic [ID_WIDTH-1:0]     s_rid,
  input  logic                    s_rlast,
  output logic                    s_rready
);
  state_t state;
  logic gnt, prio, ar_done, aw_done, w_done;
  logic win, win_vld, rd, wr, r0, r1, w0, w1;
  rr_pick2 u_pick (
    .req     ({m1_arvalid | m1_awvalid, m0_arvalid | m0_awvalid}),
    .prio    (prio),
    .gnt_idx (win),
    .gnt_vld (win_vld)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      gnt     <= 1'b0;
      prio    <= 1'b0;
      ar_done <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          ar_done <= 1'b0;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          if (win_vld) begin
            state <= (win ? m1_arvalid : m0_arvalid) ? ST_RD : ST_WR;
            gnt   <= win;
          end
        end
        ST_RD: begin
          if (s_arvalid && s_arready) ar_done <= 1'b1;
          if (s_rvalid && s_rready && s_rlast) begin
            state <= ST_IDLE;
            prio  <= ~gnt;
          end
        end
        ST_WR: begin
          if (s_awvalid && s_awready) aw_done <= 1'b1;
          if (s_wvalid && s_wready && s_wlast) w_done <= 1'b1;
          if (s_bvalid && s_bready) begin
            state <= ST_IDLE;
            prio  <= ~gnt;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
  assign rd = state == ST_RD;
  assign wr = state == ST_WR;
  assign r0 = rd & ~gnt;
  assign r1 = rd & gnt;
  assign w0 = wr & ~gnt;
  assign w1 = wr & gnt;
  // Slave side: owner's request channels, masked once their handshake is done.
  assign s_arvalid = rd & ~ar_done & (gnt ? m1_arvalid : m0_arvalid);
  assign s_araddr  = rd ? (gnt ? m1_araddr : m0_araddr) : '0;
  assign s_arid    = rd ? (gnt ? m1_arid : m0_arid) : '0;
  assign s_arlen   = rd ? (gnt ? m1_arlen : m0_arlen) : '0;
  assign s_arsize  = rd ? (gnt ? m1_arsize : m0_arsize) : '0;
  assign s_arburst = rd ? (gnt ? m1_arburst : m0_arburst) : '0;
  assign s_rready  = rd & (gnt ? m1_rready : m0_rready);
  assign s_awvalid = wr & ~aw_done & (gnt ? m1_awvalid : m0_awvalid);
  assign s_awaddr  = wr ? (gnt ? m1_awaddr : m0_awaddr) : '0;
  assign s_awid    = wr ? (gnt ? m1_awid : m0_awid) : '0;
  assign s_awlen   = wr ? (gnt ? m1_awlen : m0_awlen) : '0;
  assign s_awsize  = wr ? (gnt ? m1_awsize : m0_awsize) : '0;
  assign s_awburst = wr ? (gnt ? m1_awburst : m0_awburst) : '0;
  assign s_wvalid  = wr & ~w_done & (gnt ? m1_wvalid : m0_wvalid);
  assign s_wdata   = wr ? (gnt ? m1_wdata : m0_wdata) : '0;
  assign s_wstrb   = wr ? (gnt ? m1_wstrb : m0_wstrb) : '0;
  assign s_wlast   = wr & (gnt ? m1_wlast : m0_wlast);
  assign s_bready  = wr & (gnt ? m1_bready : m0_bready);
  // Master side: only the owner sees readies and responses; everything else reads 0.
  assign m0_arready = r0 & ~ar_done & s_arready;
  assign m0_rvalid  = r0 & s_rvalid;
  assign m0_rdata   = r0 ? s_rdata : '0;
  assign m0_rresp   = r0 ? s_rresp : '0;
  assign m0_rid     = r0 ? s_rid : '0;
  assign m0_rlast   = r0 & s_rlast;
  assign m0_awready = w0 & ~aw_done & s_awready;
  assign m0_wready  = w0 & ~w_done & s_wready;
  assign m0_bvalid  = w0 & s_bvalid;
  assign m0_bresp   = w0 ? s_bresp : '0;
  assign m0_bid     = w0 ? s_bid : '0;
  assign m1_arready = r1 & ~ar_done & s_arready;
  assign m1_rvalid  = r1 & s_rvalid;
  assign m1_rdata   = r1 ? s_rdata : '0;
  assign m1_rresp   = r1 ? s_rresp : '0;
  assign m1_rid     = r1 ? s_rid : '0;
  assign m1_rlast   = r1 & s_rlast;
  assign m1_awready = w1 & ~aw_done & s_awready;
  assign m1_wready  = w1 & ~w_done & s_wready;
  assign m1_bvalid  = w1 & s_bvalid;
  assign m1_bresp   = w1 ? s_bresp : '0;
  assign m1_bid     = w1 ? s_bid : '0;
endmodule

// File: tb/tb_axi_arbiter_2to1.sv
// tb_axi_arbiter_2to1: directed scenarios against a small behavioural AXI slave.
module tb_axi_arbiter_2to1;
  import axi_arbiter_2to1_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic [1:0] arvalid = '0, arready, rvalid, rready = 2'b11, rlast;
  logic [1:0] awvalid = '0, awready, wvalid = '0, wready, wlast = '0, bvalid, bready = 2'b11;
  logic [31:0] araddr [2], awaddr [2], wdata [2], rdata [2];
  logic [3:0]  arid [2], awid [2], rid [2], bid [2], wstrb [2];
  logic [7:0]  arlen [2], awlen [2];
  logic [2:0]  arsize [2], awsize [2];
  logic [1:0]  arburst [2], awburst [2], rresp [2], bresp [2];
  logic        s_awvalid, s_wvalid, s_wlast, s_bready, s_arvalid, s_rready;
  logic        s_awready = 1'b1, s_wready = 1'b1, s_arready = 1'b1;
  logic        s_bvalid = 1'b0, s_rvalid = 1'b0, s_rlast = 1'b0;
  logic [31:0] s_awaddr, s_araddr, s_wdata, s_rdata = '0;
  logic [3:0]  s_awid, s_arid, s_wstrb, s_bid = '0, s_rid = '0;
  logic [7:0]  s_awlen, s_arlen;
  logic [2:0]  s_awsize, s_arsize;
  logic [1:0]  s_awburst, s_arburst, s_bresp = '0, s_rresp = '0;
  int vec = 0, miss = 0;
  // Behavioural slave state.
  logic r_pend = 0, r_stall = 0, aw_got = 0, w_got = 0, bv = 0;
  logic [7:0] r_len = 0, r_beat = 0;
  logic [3:0] r_id = 0, b_id = 0, last_wstrb = 0;
  logic [1:0] r_resp = RESP_OKAY;
  logic [31:0] last_awaddr = 0, last_wdata = 0;
  int w_beats = 0, writes = 0;

  axi_arbiter_2to1 dut (
    .clk(clk), .reset(reset),
    .m0_awvalid(awvalid[0]), .m0_awaddr(awaddr[0]), .m0_awid(awid[0]), .m0_awlen(awlen[0]),
    .m0_awsize(awsize[0]), .m0_awburst(awburst[0]), .m0_awready(awready[0]),
    .m0_wvalid(wvalid[0]), .m0_wdata(wdata[0]), .m0_wstrb(wstrb[0]), .m0_wlast(wlast[0]), .m0_wready(wready[0]),
    .m0_bvalid(bvalid[0]), .m0_bresp(bresp[0]), .m0_bid(bid[0]), .m0_bready(bready[0]),
    .m0_arvalid(arvalid[0]), .m0_araddr(araddr[0]), .m0_arid(arid[0]), .m0_arlen(arlen[0]),
    .m0_arsize(arsize[0]), .m0_arburst(arburst[0]), .m0_arready(arready[0]),
    .m0_rvalid(rvalid[0]), .m0_rdata(rdata[0]), .m0_rresp(rresp[0]), .m0_rid(rid[0]), .m0_rlast(rlast[0]), .m0_rready(rready[0]),
    .m1_awvalid(awvalid[1]), .m1_awaddr(awaddr[1]), .m1_awid(awid[1]), .m1_awlen(awlen[1]),
    .m1_awsize(awsize[1]), .m1_awburst(awburst[1]), .m1_awready(awready[1]),
    .m1_wvalid(wvalid[1]), .m1_wdata(wdata[1]), .m1_wstrb(wstrb[1]), .m1_wlast(wlast[1]), .m1_wready(wready[1]),
    .m1_bvalid(bvalid[1]), .m1_bresp(bresp[1]), .m1_bid(bid[1]), .m1_bready(bready[1]),
    .m1_arvalid(arvalid[1]), .m1_araddr(araddr[1]), .m1_arid(arid[1]), .m1_arlen(arlen[1]),
    .m1_arsize(arsize[1]), .m1_arburst(arburst[1]), .m1_arready(arready[1]),
    .m1_rvalid(rvalid[1]), .m1_rdata(rdata[1]), .m1_rresp(rresp[1]), .m1_rid(rid[1]), .m1_rlast(rlast[1]), .m1_rready(rready[1]),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bid(s_bid), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rid(s_rid), .s_rlast(s_rlast), .s_rready(s_rready)
  );

  // One clock: sample slave-side handshakes before the edge, then update the slave model after it.
  task automatic tick();
    logic arf, rf, rl, awf, wf, wl, bf;
    logic [7:0] al;
    logic [3:0] ai, wi, ws;
    logic [31:0] aa, wd;
    #1;
    arf = s_arvalid & s_arready; al = s_arlen; ai = s_arid;
    rf = s_rvalid & s_rready; rl = s_rlast;
    awf = s_awvalid & s_awready; wi = s_awid; aa = s_awaddr;
    wf = s_wvalid & s_wready; wl = s_wlast; wd = s_wdata; ws = s_wstrb;
    bf = s_bvalid & s_bready;
    @(posedge clk);
    #1;
    if (reset) begin
      r_pend = 0; bv = 0; aw_got = 0; w_got = 0;
    end else begin
      if (arf) begin r_len = al; r_id = ai; r_beat = 0; r_pend = 1; end
      if (rf) begin
        if (rl) r_pend = 0;
        else r_beat = r_beat + 8'd1;
      end
      if (awf) begin aw_got = 1; b_id = wi; last_awaddr = aa; end
      if (wf) begin w_beats++; last_wdata = wd; last_wstrb = ws; if (wl) w_got = 1; end
      if (bf) begin bv = 0; aw_got = 0; w_got = 0; writes++; end
      else if (aw_got && w_got) bv = 1;
    end
    s_rvalid = r_pend & ~r_stall;
    s_rdata  = 32'hA5 + 32'(r_beat);
    s_rid    = r_id;
    s_rlast  = r_beat == r_len;
    s_rresp  = r_resp;
    s_bvalid = bv;
    s_bid    = b_id;
    s_bresp  = RESP_OKAY;
  endtask

  task automatic test_reset();
    reset = 1; tick(); tick(); reset = 0; #1;
    vec++; if (dut.state !== ST_IDLE || dut.gnt !== 1'b0 || dut.prio !== 1'b0) begin
      miss++; $display("FAIL reset_regs: state=%0d gnt=%0b prio=%0b, want 0/0/0", dut.state, dut.gnt, dut.prio); end
    vec++; if ({arready, awready, wready, rvalid, bvalid} !== 10'h0) begin
      miss++; $display("FAIL reset_master_handshakes: got %h, want 0", {arready, awready, wready, rvalid, bvalid}); end
    vec++; if ({s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready} !== 5'h0) begin
      miss++; $display("FAIL reset_slave_handshakes: got %b, want 0", {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}); end
    vec++; if (s_araddr !== 0 || s_awaddr !== 0 || s_wdata !== 0 || rdata[0] !== 0 || rdata[1] !== 0) begin
      miss++; $display("FAIL reset_data: araddr=%h awaddr=%h wdata=%h rdata0=%h rdata1=%h, want 0", s_araddr, s_awaddr, s_wdata, rdata[0], rdata[1]); end
  endtask

  task automatic test_single_read();
    arvalid[0] = 1; araddr[0] = 32'h1000_0000; arid[0] = 4'h3; arlen[0] = 0; arsize[0] = 3'd2; arburst[0] = 2'd1;
    #1;
    vec++; if (s_arvalid !== 1'b0 || arready[0] !== 1'b0) begin
      miss++; $display("FAIL rd_bubble: s_arvalid=%b arready0=%b, want 0/0", s_arvalid, arready[0]); end
    tick(); #1;
    vec++; if (s_arvalid !== 1'b1 || s_araddr !== 32'h1000_0000 || arready[0] !== 1'b1 || s_arid !== 4'h3) begin
      miss++; $display("FAIL rd_ar_route: s_arvalid=%b addr=%h id=%h arready0=%b, want 1/10000000/3/1", s_arvalid, s_araddr, s_arid, arready[0]); end
    tick(); arvalid[0] = 0; #1;
    vec++; if (rvalid[0] !== 1'b1 || rdata[0] !== 32'hA5 || rlast[0] !== 1'b1 || rid[0] !== 4'h3 || rvalid[1] !== 1'b0) begin
      miss++; $display("FAIL rd_r_route: rvalid0=%b rdata0=%h rlast0=%b rid0=%h rvalid1=%b, want 1/a5/1/3/0", rvalid[0], rdata[0], rlast[0], rid[0], rvalid[1]); end
    tick(); #1;
    vec++; if (dut.state !== ST_IDLE || dut.prio !== 1'b1) begin
      miss++; $display("FAIL rd_exit: state=%0d prio=%b, want 0/1", dut.state, dut.prio); end
  endtask

  task automatic test_write_uart();
    int wr0;
    logic bad0, got_b, af, wf;
    logic [1:0] br;
    logic [3:0] bi;
    wr0 = writes; bad0 = 0; got_b = 0; br = 2'bxx; bi = 4'hx;
    awvalid[1] = 1; awaddr[1] = 32'h1000_0000; awid[1] = 4'h9; awlen[1] = 0; awsize[1] = 0; awburst[1] = 2'd1;
    wvalid[1] = 1; wdata[1] = 32'h41; wstrb[1] = 4'b0001; wlast[1] = 1;
    for (int c = 0; c < 20 && !got_b; c++) begin
      #1;
      if (arready[0] | awready[0] | wready[0] | rvalid[0] | bvalid[0]) bad0 = 1;
      af = awvalid[1] & awready[1];
      wf = wvalid[1] & wready[1];
      if (bvalid[1]) begin got_b = 1; br = bresp[1]; bi = bid[1]; end
      tick();
      if (af) awvalid[1] = 0;
      if (wf) wvalid[1] = 0;
    end
    #1;
    vec++; if (got_b !== 1'b1 || br !== RESP_OKAY || bi !== 4'h9) begin
      miss++; $display("FAIL wr_b: got_b=%b bresp=%b bid=%h, want 1/00/9", got_b, br, bi); end
    vec++; if (last_awaddr !== 32'h1000_0000 || last_wdata !== 32'h41 || last_wstrb !== 4'b0001) begin
      miss++; $display("FAIL wr_slave_payload: awaddr=%h wdata=%h wstrb=%b, want 10000000/41/0001", last_awaddr, last_wdata, last_wstrb); end
    vec++; if (bad0 !== 1'b0) begin
      miss++; $display("FAIL wr_m0_quiet: m0 handshake seen=%b, want 0", bad0); end
    vec++; if (writes - wr0 !== 1 || dut.state !== ST_IDLE || dut.prio !== 1'b0) begin
      miss++; $display("FAIL wr_exit: writes=%0d state=%0d prio=%b, want 1/0/0", writes - wr0, dut.state, dut.prio); end
  endtask

  task automatic test_contention();
    logic [7:0] seq;
    int left [2];
    int nr, idbad;
    logic [1:0] f;
    seq = 0; nr = 0; idbad = 0; left[0] = 2; left[1] = 2;
    arid[0] = 4'h3; arid[1] = 4'h5; arlen[0] = 0; arlen[1] = 0;
    araddr[0] = 32'h0000_0100; araddr[1] = 32'h0000_0200;
    arvalid = 2'b11;
    for (int c = 0; c < 60 && nr < 4; c++) begin
      #1;
      f = arvalid & arready;
      for (int k = 0; k < 2; k++) begin
        if (f[k]) seq = {seq[5:0], 2'(k)};
        if (rvalid[k] && rready[k]) begin nr++; if (rid[k] !== arid[k]) idbad++; end
      end
      tick();
      for (int k = 0; k < 2; k++) if (f[k]) begin left[k]--; if (left[k] == 0) arvalid[k] = 0; end
    end
    vec++; if (seq !== 8'b00_01_00_01) begin
      miss++; $display("FAIL rr_order: grant sequence=%b, want 00010001", seq); end
    vec++; if (nr !== 4 || idbad !== 0) begin
      miss++; $display("FAIL rr_ids: responses=%0d bad ids=%0d, want 4/0", nr, idbad); end
  endtask

  task automatic test_w_before_aw();
    int wb0, wr0, nb;
    logic early, leak, wfired, af, wf;
    wb0 = w_beats; wr0 = writes; nb = 0; early = 0; leak = 0; wfired = 0;
    wvalid[1] = 1; wdata[1] = 32'h77; wstrb[1] = 4'hF; wlast[1] = 1;
    for (int c = 0; c < 2; c++) begin
      #1;
      if (s_wvalid | wready[1]) early = 1;
      tick();
    end
    vec++; if (early !== 1'b0) begin
      miss++; $display("FAIL wfirst_idle: W handshake visible before AW=%b, want 0", early); end
    s_awready = 0;
    awvalid[1] = 1; awaddr[1] = 32'h2000_0000; awid[1] = 4'hC; awlen[1] = 0;
    for (int c = 0; c < 20 && nb == 0; c++) begin
      if (c == 2) s_awready = 1;
      #1;
      if (wfired && (s_wvalid || wready[1])) leak = 1;
      af = awvalid[1] & awready[1];
      wf = wvalid[1] & wready[1];
      if (bvalid[1]) nb++;
      tick();
      if (af) awvalid[1] = 0;
      if (wf) begin wfired = 1; wdata[1] = 32'h88; end
    end
    wvalid[1] = 0;
    for (int c = 0; c < 3; c++) begin #1; if (bvalid[1]) nb++; tick(); end
    vec++; if (w_beats - wb0 !== 1 || last_wdata !== 32'h77) begin
      miss++; $display("FAIL wfirst_beats: slave W beats=%0d last=%h, want 1/77", w_beats - wb0, last_wdata); end
    vec++; if (nb !== 1 || writes - wr0 !== 1) begin
      miss++; $display("FAIL wfirst_b: B count=%0d writes=%0d, want 1/1", nb, writes - wr0); end
    vec++; if (leak !== 1'b0) begin
      miss++; $display("FAIL wfirst_mask: W leaked after wlast=%b, want 0", leak); end
  endtask

  task automatic test_burst_read();
    int b0, b1, dbad, rbad;
    logic last0, early1, done;
    logic [1:0] f;
    b0 = 0; b1 = 0; dbad = 0; rbad = 0; last0 = 0; early1 = 0; done = 0;
    r_resp = RESP_SLVERR;
    arvalid = 2'b11;
    araddr[0] = 32'h3000_0000; arid[0] = 4'h2; arlen[0] = 8'd3;
    araddr[1] = 32'h4000_0000; arid[1] = 4'h6; arlen[1] = 8'd0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      f = arvalid & arready;
      if (arready[1] && !last0) early1 = 1;
      if (rvalid[0]) begin
        if (rdata[0] !== 32'hA5 + 32'(b0)) dbad++;
        if (rresp[0] !== RESP_SLVERR) rbad++;
        b0++;
        if (rlast[0]) last0 = 1;
      end
      if (rvalid[1]) begin b1++; if (!last0) early1 = 1; if (rlast[1]) done = 1; end
      tick();
      for (int k = 0; k < 2; k++) if (f[k]) arvalid[k] = 0;
    end
    r_resp = RESP_OKAY;
    vec++; if (b0 !== 4 || dbad !== 0) begin
      miss++; $display("FAIL burst_beats: m0 beats=%0d bad data=%0d, want 4/0", b0, dbad); end
    vec++; if (rbad !== 0) begin
      miss++; $display("FAIL burst_resp: rresp mismatches=%0d, want 0", rbad); end
    vec++; if (early1 !== 1'b0 || b1 !== 1) begin
      miss++; $display("FAIL burst_hold: m1 early=%b m1 beats=%0d, want 0/1", early1, b1); end
  endtask

  task automatic test_reset_mid_rd();
    logic gone, f;
    gone = 0;
    arvalid[0] = 1; arid[0] = 4'h1; arlen[0] = 0;
    for (int c = 0; c < 20 && !gone; c++) begin
      #1;
      f = arready[0];
      if (rvalid[0] && rlast[0]) gone = 1;
      tick();
      if (f) arvalid[0] = 0;
    end
    r_stall = 1; gone = 0;
    arvalid[1] = 1; arid[1] = 4'h7; arlen[1] = 0;
    for (int c = 0; c < 20 && !gone; c++) begin
      #1;
      gone = arready[1];
      tick();
      if (gone) arvalid[1] = 0;
    end
    #1;
    vec++; if (dut.state !== ST_RD || dut.prio !== 1'b1 || s_rready !== 1'b1) begin
      miss++; $display("FAIL mid_rd_setup: state=%0d prio=%b s_rready=%b, want 1/1/1", dut.state, dut.prio, s_rready); end
    reset = 1;
    tick(); #1;
    vec++; if (dut.state !== ST_IDLE || dut.prio !== 1'b0) begin
      miss++; $display("FAIL mid_rd_regs: state=%0d prio=%b, want 0/0", dut.state, dut.prio); end
    vec++; if ({arready, rvalid, awready, wready, bvalid, s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready} !== 15'h0) begin
      miss++; $display("FAIL mid_rd_outputs: got %h, want 0", {arready, rvalid, awready, wready, bvalid, s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready}); end
    reset = 0; r_stall = 0;
    tick();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      araddr[k] = 0; awaddr[k] = 0; wdata[k] = 0; arid[k] = 0; awid[k] = 0; wstrb[k] = 0;
      arlen[k] = 0; awlen[k] = 0; arsize[k] = 0; awsize[k] = 0; arburst[k] = 0; awburst[k] = 0;
    end
    test_reset();
    test_single_read();
    test_write_uart();
    test_contention();
    test_w_before_aw();
    test_burst_read();
    test_reset_mid_rd();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
